// File: rtl/pdm_mic_pkg.sv
// Shared state encoding, default parameters and helpers for the PDM mic
// controller and its peak-window sub-block.
package pdm_mic_pkg;

  localparam int DEF_SAMPLE_DEPTH   = 16;
  localparam int DEF_WARMUP_SAMPLES = 4096;
  localparam int DEF_DECIM          = 64;
  localparam int DEF_WINDOW_LOG2    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } mic_state_t;

  // Magnitude of a sign-extended w-bit sample; the most negative code maps to
  // the largest positive code so the result always fits in w-1 bits.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v,
                                          input int unsigned w);
    logic [31:0] max_pos;
    logic [31:0] a;
    max_pos = (32'd1 << (w - 1)) - 32'd1;
    a = v[31] ? 32'(-v) : 32'(v);
    return (a > max_pos) ? max_pos : a;
  endfunction

endpackage

// File: rtl/mic_peak_window.sv
// Windowed peak-magnitude tracker: reports the largest |sample| seen in each
// complete window of 2^WINDOW_LOG2 strobes.
module mic_peak_window
  import pdm_mic_pkg::*;
#(
  parameter int SAMPLE_DEPTH = DEF_SAMPLE_DEPTH,
  parameter int WINDOW_LOG2  = DEF_WINDOW_LOG2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           stb,
  input  logic signed [SAMPLE_DEPTH-1:0] sample,
  output logic        [SAMPLE_DEPTH-2:0] level,
  output logic                           level_stb
);

  logic [SAMPLE_DEPTH-2:0] peak;
  logic [SAMPLE_DEPTH-2:0] mag;
  logic [SAMPLE_DEPTH-2:0] peak_nxt;
  logic [WINDOW_LOG2-1:0]  win_cnt;

  assign mag      = (SAMPLE_DEPTH-1)'(sat_abs(32'(sample), SAMPLE_DEPTH));
  assign peak_nxt = (mag > peak) ? mag : peak;

  always_ff @(posedge clk) begin
    if (!rst) begin
      peak      <= '0;
      win_cnt   <= '0;
      level     <= '0;
      level_stb <= 1'b0;
    end else begin
      level_stb <= 1'b0;
      if (clear) begin
        peak    <= '0;
        win_cnt <= '0;
      end else if (stb) begin
        win_cnt <= win_cnt + 1'b1;
        // Last strobe of the window is folded in before the level is published.
        if (&win_cnt) begin
          level     <= peak_nxt;
          level_stb <= 1'b1;
          peak      <= '0;
        end else begin
          peak <= peak_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/pdm_mic_ctrl.sv
// PDM mic sequencer: warm-up gating, decimation with valid/ready output,
// overrun flag and windowed peak level.
//   state  | meaning
//   IDLE   | mic off, strobes ignored
//   WARMUP | mic on, discarding WARMUP_SAMPLES settling strobes
//   RUN    | mic on, decimating to sample_out and tracking peak level
module pdm_mic_ctrl
  import pdm_mic_pkg::*;
#(
  parameter int SAMPLE_DEPTH   = DEF_SAMPLE_DEPTH,
  parameter int WARMUP_SAMPLES = DEF_WARMUP_SAMPLES,
  parameter int DECIM          = DEF_DECIM,
  parameter int WINDOW_LOG2    = DEF_WINDOW_LOG2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  output logic                           mic_en,
  input  logic signed [SAMPLE_DEPTH-1:0] audio_in,
  input  logic                           audio_stb,
  output logic signed [SAMPLE_DEPTH-1:0] sample_out,
  output logic                           sample_valid,
  input  logic                           sample_ready,
  output logic        [SAMPLE_DEPTH-2:0] level,
  output logic                           level_stb,
  output logic                           overrun,
  input  logic                           clr_overrun,
  output logic        [1:0]              state
);

  localparam logic [15:0] WARM_LAST = 16'(WARMUP_SAMPLES - 1);
  localparam logic [7:0]  DEC_LAST  = 8'(DECIM - 1);

  mic_state_t  st;
  logic [15:0] warm_cnt;
  logic [7:0]  dec_cnt;
  logic        keep;
  logic        pk_stb;
  logic        pk_clr;

  assign state  = st;
  assign keep   = audio_stb && (dec_cnt == 8'd0);
  assign pk_stb = audio_stb && enable && (st == ST_RUN);
  assign pk_clr = !enable;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st           <= ST_IDLE;
      mic_en       <= 1'b0;
      warm_cnt     <= '0;
      dec_cnt      <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (clr_overrun)
        overrun <= 1'b0;
      if (!enable) begin
        st           <= ST_IDLE;
        mic_en       <= 1'b0;
        sample_valid <= 1'b0;
        warm_cnt     <= '0;
        dec_cnt      <= '0;
      end else begin
        case (st)
          ST_IDLE: begin
            st       <= ST_WARMUP;
            mic_en   <= 1'b1;
            warm_cnt <= '0;
            dec_cnt  <= '0;
          end
          ST_WARMUP: begin
            if (audio_stb) begin
              if (warm_cnt == WARM_LAST) begin
                st       <= ST_RUN;
                warm_cnt <= '0;
                dec_cnt  <= '0;
              end else begin
                warm_cnt <= warm_cnt + 16'd1;
              end
            end
          end
          ST_RUN: begin
            if (audio_stb)
              dec_cnt <= (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
            // A full output register with no accept this cycle drops the new
            // sample; the drop outranks a concurrent overrun clear.
            if (keep) begin
              if (!sample_valid || sample_ready) begin
                sample_out   <= audio_in;
                sample_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else if (sample_valid && sample_ready) begin
              sample_valid <= 1'b0;
            end
          end
          default: begin
            st     <= ST_IDLE;
            mic_en <= 1'b0;
          end
        endcase
      end
    end
  end

  mic_peak_window #(
    .SAMPLE_DEPTH (SAMPLE_DEPTH),
    .WINDOW_LOG2  (WINDOW_LOG2)
  ) u_peak (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clr),
    .stb       (pk_stb),
    .sample    (audio_in),
    .level     (level),
    .level_stb (level_stb)
  );

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Directed, table-driven bench for pdm_mic_ctrl with a short warm-up, DECIM=4
// and a 4-strobe peak window.
module tb_pdm_mic_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        mic_en;
  logic [15:0] audio_in = '0;
  logic        audio_stb = 1'b0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic [14:0] level;
  logic        level_stb;
  logic        overrun;
  logic        clr_overrun = 1'b0;
  logic [1:0]  state;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [15:0] val;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [15:0] eout;
    logic        eovr;
    logic [14:0] elvl;
    logic        elstb;
    logic        ev2;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pdm_mic_ctrl #(
    .SAMPLE_DEPTH   (16),
    .WARMUP_SAMPLES (8),
    .DECIM          (4),
    .WINDOW_LOG2    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mic_en       (mic_en),
    .audio_in     (audio_in),
    .audio_stb    (audio_stb),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .level        (level),
    .level_stb    (level_stb),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun),
    .state        (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] v);
    audio_in  = v;
    audio_stb = 1'b1;
    tick();
    audio_stb = 1'b0;
  endtask

  task automatic add(input int val, input bit rdy, input bit clr, input bit ev,
                     input int eout, input bit eovr, input int elvl,
                     input bit elstb, input bit ev2);
    vecs.push_back(vec_t'{16'(val), rdy, clr, ev, 16'(eout), eovr, 15'(elvl), elstb, ev2});
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sample_ready = vecs[i].rdy;
      clr_overrun  = vecs[i].clr;
      strobe(vecs[i].val);
      clr_overrun  = 1'b0;
      chk($sformatf("r%0d_valid", i), 32'(sample_valid), 32'(vecs[i].ev));
      chk($sformatf("r%0d_out", i), 32'(sample_out), 32'(vecs[i].eout));
      chk($sformatf("r%0d_overrun", i), 32'(overrun), 32'(vecs[i].eovr));
      chk($sformatf("r%0d_level", i), 32'(level), 32'(vecs[i].elvl));
      chk($sformatf("r%0d_level_stb", i), 32'(level_stb), 32'(vecs[i].elstb));
      tick();
      chk($sformatf("r%0d_valid_next", i), 32'(sample_valid), 32'(vecs[i].ev2));
      chk($sformatf("r%0d_level_stb_next", i), 32'(level_stb), 32'd0);
      tick();
      tick();
    end
  endtask

  task automatic warmup(input string tag);
    bit saw_valid;
    saw_valid = 1'b0;
    sample_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      strobe(16'(77 + i));
      if (sample_valid) saw_valid = 1'b1;
      if (i == 6) chk({tag, "_state_before_last"}, 32'(state), 32'd1);
      tick();
      tick();
      tick();
    end
    chk({tag, "_state_run"}, 32'(state), 32'd2);
    chk({tag, "_no_valid"}, 32'(saw_valid), 32'd0);
  endtask

  initial begin
    // Segment 1: first kept sample, decimation, backpressure with drop.
    add(100, 0, 0, 1, 100, 0, 0, 0, 1);
    add(0, 1, 0, 0, 100, 0, 0, 0, 0);
    add(0, 1, 0, 0, 100, 0, 0, 0, 0);
    add(0, 1, 0, 0, 100, 0, 100, 1, 0);
    for (int k = 1; k <= 16; k++)
      add(k, 1, 0, (k % 4) == 1, k - ((k - 1) % 4), 0,
          (k < 4) ? 100 : (k / 4) * 4, (k % 4) == 0, 0);
    add(10, 0, 0, 1, 10, 0, 16, 0, 1);
    add(0, 0, 0, 1, 10, 0, 16, 0, 1);
    add(0, 0, 0, 1, 10, 0, 16, 0, 1);
    add(0, 0, 0, 1, 10, 0, 10, 1, 1);
    add(20, 0, 0, 1, 10, 1, 10, 0, 1);
    // Segment 2: simultaneous accept+load, peak windows, drop racing clear.
    add(0, 1, 0, 0, 10, 0, 10, 0, 0);
    add(0, 1, 0, 0, 10, 0, 10, 0, 0);
    add(0, 1, 0, 0, 10, 0, 20, 1, 0);
    add(10, 0, 0, 1, 10, 0, 20, 0, 1);
    add(0, 0, 0, 1, 10, 0, 20, 0, 1);
    add(0, 0, 0, 1, 10, 0, 20, 0, 1);
    add(0, 0, 0, 1, 10, 0, 10, 1, 1);
    add(30, 1, 0, 1, 30, 0, 10, 0, 0);
    add(0, 1, 0, 0, 30, 0, 10, 0, 0);
    add(0, 1, 0, 0, 30, 0, 10, 0, 0);
    add(0, 1, 0, 0, 30, 0, 30, 1, 0);
    add(-5, 1, 0, 1, -5, 0, 30, 0, 0);
    add(7, 1, 0, 0, -5, 0, 30, 0, 0);
    add(-32768, 1, 0, 0, -5, 0, 30, 0, 0);
    add(3, 1, 0, 0, -5, 0, 32767, 1, 0);
    add(1, 1, 0, 1, 1, 0, 32767, 0, 0);
    add(-2, 1, 0, 0, 1, 0, 32767, 0, 0);
    add(0, 1, 0, 0, 1, 0, 32767, 0, 0);
    add(1, 1, 0, 0, 1, 0, 2, 1, 0);
    add(50, 0, 0, 1, 50, 0, 2, 0, 1);
    add(0, 0, 0, 1, 50, 0, 2, 0, 1);
    add(0, 0, 0, 1, 50, 0, 2, 0, 1);
    add(0, 0, 0, 1, 50, 0, 50, 1, 1);
    add(60, 0, 1, 1, 50, 1, 50, 0, 1);

    repeat (3) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mic_en", 32'(mic_en), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_out", 32'(sample_out), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_level_stb", 32'(level_stb), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    rst = 1'b1;
    strobe(16'd55);
    chk("idle_stb_state", 32'(state), 32'd0);
    chk("idle_stb_mic_en", 32'(mic_en), 32'd0);
    tick();
    tick();

    enable = 1'b1;
    chk("mic_en_before_edge", 32'(mic_en), 32'd0);
    tick();
    chk("mic_en_after_enable", 32'(mic_en), 32'd1);
    chk("state_warmup", 32'(state), 32'd1);
    warmup("warm1");

    run_rows(0, 24);

    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("clr_overrun", 32'(overrun), 32'd0);
    chk("clr_keeps_valid", 32'(sample_valid), 32'd1);
    chk("clr_keeps_out", 32'(sample_out), 32'd10);
    sample_ready = 1'b1;
    tick();
    chk("ready_clears_valid", 32'(sample_valid), 32'd0);

    run_rows(25, 48);

    enable = 1'b0;
    tick();
    chk("dis_state", 32'(state), 32'd0);
    chk("dis_mic_en", 32'(mic_en), 32'd0);
    chk("dis_valid", 32'(sample_valid), 32'd0);
    chk("dis_level_held", 32'(level), 32'd50);
    chk("dis_overrun_held", 32'(overrun), 32'd1);

    enable = 1'b1;
    tick();
    chk("reen_state", 32'(state), 32'd1);
    chk("reen_mic_en", 32'(mic_en), 32'd1);
    warmup("warm2");
    strobe(16'd123);
    chk("reen_first_out", 32'(sample_out), 32'd123);
    chk("reen_first_valid", 32'(sample_valid), 32'd1);
    chk("reen_overrun_held", 32'(overrun), 32'd1);
    tick();

    rst = 1'b0;
    tick();
    chk("rst2_overrun", 32'(overrun), 32'd0);
    chk("rst2_level", 32'(level), 32'd0);
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_valid", 32'(sample_valid), 32'd0);
    chk("rst2_out", 32'(sample_out), 32'd0);
    chk("rst2_mic_en", 32'(mic_en), 32'd0);
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
